carregador_imem: RTL and testbench

- Writer side of the instruction memory. Receives a byte stream from a host link (UART receiver or testbench) over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them sequentially into the 64x32 instruction memory through a synchronous write port.
- Holds the processor in reset until the image is loaded and the checksum passes.
- Sits between the host byte link and the instruction memory, ahead of the fetch stage.

---
 rtl/carregador_imem_pkg.sv | 19 +
 rtl/carregador_imem_montador_palavra.sv | 53 +++++
 rtl/carregador_imem.sv | 138 +++++++++++++
 tb/tb_carregador_imem.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/carregador_imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and stream constants.
package carregador_imem_pkg;

    localparam int ADDR_W            = 6;
    localparam int DATA_W            = 32;
    localparam int BYTES_POR_PALAVRA = 4;
    localparam int MAX_WORDS         = 64;
    // A header byte of zero stands for a full memory image.
    localparam int N_ZERO_PALAVRAS   = MAX_WORDS;

    typedef enum logic [2:0] {
        OCIOSO,
        CABECALHO,
        BYTES,
        ESCREVE,
        VERIFICA
    } estado_t;

endpackage

// File: rtl/carregador_imem_montador_palavra.sv
// Assembles little-endian words from a byte strobe and keeps the running XOR checksum.
module montador_palavra
    import carregador_imem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        limpa,
    input  logic        strobe,
    input  logic [7:0]  byte_in,
    output logic [31:0] palavra,
    output logic        completa,
    output logic [7:0]  checksum
);

    localparam int LANE_W = $clog2(BYTES_POR_PALAVRA);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       palavra_q, palavra_d;
    logic [7:0]        checksum_q, checksum_d;

    always_comb begin
        lane_d     = lane_q;
        palavra_d  = palavra_q;
        checksum_d = checksum_q;
        if (limpa) begin
            lane_d     = '0;
            palavra_d  = '0;
            checksum_d = '0;
        end else if (strobe) begin
            palavra_d[8*lane_q +: 8] = byte_in;
            lane_d                   = lane_q + 1'b1;
            checksum_d               = checksum_q ^ byte_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q     <= '0;
            palavra_q  <= '0;
            checksum_q <= '0;
        end else begin
            lane_q     <= lane_d;
            palavra_q  <= palavra_d;
            checksum_q <= checksum_d;
        end
    end

    // The word includes the byte arriving now, so the writer can latch it on the same edge.
    assign palavra  = palavra_d;
    assign completa = strobe && !limpa && (lane_q == LANE_W'(BYTES_POR_PALAVRA - 1));
    assign checksum = checksum_q;

endmodule

// File: rtl/carregador_imem.sv
// Loads a byte-streamed program image into the instruction memory and releases the CPU on a good checksum.
module carregador_imem
    import carregador_imem_pkg::*;
#(
    parameter int ADDR_W_P    = ADDR_W,
    parameter int DATA_W_P    = DATA_W,
    parameter int MAX_WORDS_P = MAX_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inicio,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic                mem_we,
    output logic [ADDR_W_P-1:0] mem_endereco,
    output logic [DATA_W_P-1:0] mem_dado,
    output logic                cpu_reset,
    output logic                pronto,
    output logic                erro
);

    localparam int CW = ADDR_W_P + 1;

    estado_t               estado_q, estado_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W_P-1:0]   mem_endereco_q, mem_endereco_d;
    logic [DATA_W_P-1:0]   mem_dado_q, mem_dado_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  pronto_q, pronto_d;
    logic                  erro_q, erro_d;
    logic [CW-1:0]         cont_q, cont_d;
    logic [CW-1:0]         n_q, n_d;

    logic                  transfer;
    logic                  strobe;
    logic [31:0]           palavra;
    logic                  completa;
    logic [7:0]            checksum;

    assign transfer = byte_valid && byte_ready_q;
    assign strobe   = transfer && !inicio && (estado_q == BYTES);

    montador_palavra u_montador (
        .clk      (clk),
        .reset    (reset),
        .limpa    (inicio),
        .strobe   (strobe),
        .byte_in  (byte_in),
        .palavra  (palavra),
        .completa (completa),
        .checksum (checksum)
    );

    always_comb begin
        estado_d       = estado_q;
        mem_we_d       = 1'b0;
        mem_endereco_d = mem_endereco_q;
        mem_dado_d     = mem_dado_q;
        cpu_reset_d    = cpu_reset_q;
        pronto_d       = pronto_q;
        erro_d         = erro_q;
        cont_d         = cont_q;
        n_d            = n_q;
        // A start pulse overrides whatever the stream is doing, including a byte offered this cycle.
        if (inicio) begin
            estado_d    = CABECALHO;
            cpu_reset_d = 1'b1;
            pronto_d    = 1'b0;
            erro_d      = 1'b0;
            cont_d      = '0;
        end else begin
            case (estado_q)
                CABECALHO: if (transfer) begin
                    n_d      = (byte_in == 8'd0) ? CW'(N_ZERO_PALAVRAS) : CW'(byte_in);
                    estado_d = BYTES;
                end
                BYTES: if (completa) begin
                    estado_d       = ESCREVE;
                    mem_we_d       = 1'b1;
                    mem_endereco_d = cont_q[ADDR_W_P-1:0];
                    mem_dado_d     = DATA_W_P'(palavra);
                end
                ESCREVE: begin
                    cont_d   = cont_q + CW'(1);
                    estado_d = ((cont_q + CW'(1)) == n_q) ? VERIFICA : BYTES;
                end
                VERIFICA: if (transfer) begin
                    if (byte_in == checksum) begin
                        pronto_d    = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        erro_d = 1'b1;
                    end
                    estado_d = OCIOSO;
                end
                default: estado_d = OCIOSO;
            endcase
        end
        byte_ready_d = (estado_d == CABECALHO) || (estado_d == BYTES) || (estado_d == VERIFICA);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q       <= OCIOSO;
            byte_ready_q   <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_endereco_q <= '0;
            mem_dado_q     <= '0;
            cpu_reset_q    <= 1'b1;
            pronto_q       <= 1'b0;
            erro_q         <= 1'b0;
            cont_q         <= '0;
            n_q            <= '0;
        end else begin
            estado_q       <= estado_d;
            byte_ready_q   <= byte_ready_d;
            mem_we_q       <= mem_we_d;
            mem_endereco_q <= mem_endereco_d;
            mem_dado_q     <= mem_dado_d;
            cpu_reset_q    <= cpu_reset_d;
            pronto_q       <= pronto_d;
            erro_q         <= erro_d;
            cont_q         <= cont_d;
            n_q            <= n_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_endereco = mem_endereco_q;
    assign mem_dado     = mem_dado_q;
    assign cpu_reset    = cpu_reset_q;
    assign pronto       = pronto_q;
    assign erro         = erro_q;

endmodule

// File: tb/tb_carregador_imem.sv
// Randomized self-checking bench for carregador_imem against a stream-level reference model.
module tb_carregador_imem;

    logic        clk;
    logic        reset;
    logic        inicio;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [5:0]  mem_endereco;
    logic [31:0] mem_dado;
    logic        cpu_reset;
    logic        pronto;
    logic        erro;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_low = 0;
    int we_ready_overlap = 0;
    bit count_en = 0;

    int          acc_cyc[$];
    int          wr_cyc[$];
    logic [5:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] words[64];

    carregador_imem dut (
        .clk          (clk),
        .reset        (reset),
        .inicio       (inicio),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_endereco (mem_endereco),
        .mem_dado     (mem_dado),
        .cpu_reset    (cpu_reset),
        .pronto       (pronto),
        .erro         (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter plus a write/handshake monitor sampled just after each rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (mem_we) begin
            wr_addr.push_back(mem_endereco);
            wr_data.push_back(mem_dado);
            wr_cyc.push_back(cyc + 1);
            if (byte_ready) we_ready_overlap++;
        end
        if (count_en && !byte_ready) ready_low++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!byte_ready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL send_byte timeout observed=byte_ready 0 expected=1");
        end else begin
            acc_cyc.push_back(cyc + 1);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_inicio();
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
    endtask

    function automatic logic [7:0] image_xor(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) x ^= 8'((words[i] >> (8 * k)) & 32'hFF);
        return x;
    endfunction

    // Full load: header, payload with random gaps, checksum (optionally corrupted), then check against the model.
    task automatic do_load(input string tag, input int hdr, input logic [7:0] cks_flip,
                           input int gap_max, input bit ready_check);
        int n = (hdr == 0) ? 64 : hdr;
        logic [7:0] cks = image_xor(n);
        bit good = (cks_flip == 8'h00);
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); acc_cyc.delete();
        pulse_inicio();
        send_byte(8'(hdr));
        ready_low = 0;
        we_ready_overlap = 0;
        count_en = 1;
        for (int w = 0; w < n; w++)
            for (int k = 0; k < 4; k++) begin
                if (gap_max > 0) idle($urandom_range(gap_max, 0));
                send_byte(8'((words[w] >> (8 * k)) & 32'hFF));
            end
        count_en = 0;
        send_byte(cks ^ cks_flip);
        idle(3);
        check({tag, " write count"}, wr_addr.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check($sformatf("%s addr[%0d]", tag, i), wr_addr[i], i);
            check($sformatf("%s data[%0d]", tag, i), wr_data[i], words[i]);
            check($sformatf("%s latency[%0d]", tag, i), wr_cyc[i], acc_cyc[4 * i + 4] + 1);
        end
        check({tag, " pronto"}, pronto, good);
        check({tag, " erro"}, erro, !good);
        check({tag, " cpu_reset"}, cpu_reset, !good);
        if (ready_check) begin
            check({tag, " ready low cycles"}, ready_low, n);
            check({tag, " we with ready"}, we_ready_overlap, 0);
        end
    endtask

    initial begin
        logic [31:0] old0, neww;
        reset = 1'b1; inicio = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst byte_ready", byte_ready, 0);
        check("rst mem_we", mem_we, 0);
        check("rst addr", mem_endereco, 0);
        check("rst data", mem_dado, 0);
        check("rst cpu_reset", cpu_reset, 1);
        check("rst pronto", pronto, 0);
        check("rst erro", erro, 0);

        $display("[TB] directed single word");
        words[0] = 32'h00102083;
        do_load("n1", 1, 8'h00, 0, 1'b1);

        $display("[TB] three words continuous");
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        do_load("n3", 3, 8'h00, 0, 1'b1);

        $display("[TB] bad checksum");
        words[0] = 32'h00102083;
        do_load("bad", 1, 8'hB3, 0, 1'b0);

        $display("[TB] mid-stream abort");
        for (int i = 0; i < 2; i++) words[i] = $urandom;
        old0 = words[0];
        neww = $urandom;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        pulse_inicio();
        send_byte(8'd2);
        for (int b = 0; b < 6; b++) send_byte(8'((words[b / 4] >> (8 * (b % 4))) & 32'hFF));
        inicio = 1'b1; byte_valid = 1'b1; byte_in = 8'h05;
        @(negedge clk);
        inicio = 1'b0; byte_valid = 1'b0;
        send_byte(8'd1);
        for (int k = 0; k < 4; k++) send_byte(8'((neww >> (8 * k)) & 32'hFF));
        send_byte(8'((neww ^ (neww >> 8) ^ (neww >> 16) ^ (neww >> 24)) & 32'hFF));
        idle(3);
        check("abort write count", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check("abort first data", wr_data[0], old0);
            check("abort new addr", wr_addr[1], 0);
            check("abort new data", wr_data[1], neww);
        end
        check("abort pronto", pronto, 1);

        $display("[TB] full 64-word image with gaps");
        for (int i = 0; i < 64; i++) words[i] = $urandom;
        do_load("n64", 0, 8'h00, 2, 1'b0);
        check("n64 last addr", mem_endereco, 63);

        $display("[TB] async reset mid-stream");
        words[0] = $urandom; words[1] = $urandom;
        pulse_inicio();
        send_byte(8'd2);
        send_byte(8'(words[0] & 32'hFF));
        send_byte(8'((words[0] >> 8) & 32'hFF));
        byte_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst byte_ready", byte_ready, 0);
        check("arst addr", mem_endereco, 0);
        check("arst data", mem_dado, 0);
        check("arst cpu_reset", cpu_reset, 1);
        check("arst pronto", pronto, 0);
        @(negedge clk);
        reset = 1'b0;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            byte_valid = 1'b1;
            byte_in = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check("arst ignored ready", byte_ready, 0);
        check("arst ignored writes", wr_addr.size(), 0);
        check("arst cpu_reset held", cpu_reset, 1);

        $display("[TB] recovery load");
        words[0] = $urandom; words[1] = $urandom;
        do_load("rec", 2, 8'h00, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
